// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Groups the start handshake, operands and result of the bit-serial
//   subtractor so requester and datapath connect through one port.
//
//   start       request, sampled by the subtractor only while busy==0
//   a_in        minuend, captured when start is accepted
//   b_in        subtrahend, captured when start is accepted
//   borrow_in   initial borrow, captured when start is accepted
//   busy        high while bits are being processed
//   done        single-cycle pulse: diff/borrow_out valid
//   diff        (a - b - borrow_in) mod 2^WIDTH
//   borrow_out  1 iff a < b + borrow_in (unsigned)
//
//   master: the requester side; slave: the subtractor side.

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a_in, b_in, borrow_in,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a_in, b_in, borrow_in,
      output busy, done, diff, borrow_out
   );

endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b - borrow_in, computed LSB
//   first with one full-subtractor cell and a borrow flop, one bit per clock.
//   Start in cycle 0 -> busy in cycles 1..WIDTH -> done pulse in cycle
//   WIDTH+1. diff/borrow_out change only on entry to DONE and hold otherwise.
//
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   serial_subtractor_if.slave (start/operands in, busy/done/result out)

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] d_sr;      // result bits collected so far, LSB at bit 0 when complete
   logic             br;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             a_bit, b_bit;
   logic             d_bit, br_next;
   logic             last_bit;
   logic [WIDTH-1:0] d_cat;

   // Full-subtractor cell on the current LSBs.
   assign a_bit    = a_sr[0];
   assign b_bit    = b_sr[0];
   assign d_bit    = a_bit ^ b_bit ^ br;
   assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // New bit enters at the top; after the final bit this is the full result.
   assign d_cat    = {d_bit, d_sr};

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = SHIFT;
         SHIFT:   if (last_bit)  next_state = DONE;
         DONE:    next_state = bus.start ? SHIFT : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values; the reset is synchronous and clears the shift
   // registers too, so a reset mid-operation leaves no stale bits behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         d_sr     <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_sr <= bus.a_in;
                  b_sr <= bus.b_in;
                  br   <= bus.borrow_in;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               d_sr <= d_cat[WIDTH-1:1];
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               // Result registers move only when the last bit is produced.
               if (last_bit) begin
                  diff_q   <= d_cat;
                  borrow_q <= br_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state == SHIFT);
   assign bus.done       = (state == DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed checks of the 8-bit subtractor (results, latency, busy window,
//   ignored start, back-to-back start, reset abort) and an exhaustive sweep
//   of a 4-bit instance against a behavioural model.

module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One 8-bit operation: latency, busy window, result, single done pulse.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] ed, input logic eb);
      int cyc, bcnt;
      bit seen;
      @(posedge clk); #1;
      bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.borrow_in = bin;
      @(posedge clk); #1;
      // Operands may change freely after acceptance.
      bus8.start = 1'b0; bus8.a_in = ~a; bus8.b_in = ~b; bus8.borrow_in = ~bin;
      cyc = 0; bcnt = 0; seen = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus8.busy) bcnt++;
         if (bus8.done) seen = 1;
      end
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, cyc, 9);
      check({tag, " busy_cycles"}, bcnt, 8);
      check({tag, " busy_in_done"}, 32'(bus8.busy), 32'd0);
      check({tag, " diff"}, 32'(bus8.diff), 32'(ed));
      check({tag, " borrow_out"}, 32'(bus8.borrow_out), 32'(eb));
      @(negedge clk);
      check({tag, " done_single"}, 32'(bus8.done), 32'd0);
      check({tag, " diff_hold"}, 32'(bus8.diff), 32'(ed));
   endtask

   // One 4-bit operation checked against an arithmetic model.
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int cyc, full;
      bit seen;
      logic [3:0] ed;
      logic eb;
      string tag;
      full = int'(a) - int'(b) - int'(bin);
      ed   = 4'(full);
      eb   = (int'(a) < int'(b) + int'(bin));
      tag  = $sformatf("w4 a=%0h b=%0h bin=%0b", a, b, bin);
      @(posedge clk); #1;
      bus4.start = 1'b1; bus4.a_in = a; bus4.b_in = b; bus4.borrow_in = bin;
      @(posedge clk); #1;
      bus4.start = 1'b0; bus4.a_in = ~a; bus4.b_in = ~b; bus4.borrow_in = ~bin;
      cyc = 0; seen = 0;
      while (!seen && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (bus4.done) seen = 1;
      end
      check({tag, " latency"}, cyc, 5);
      check({tag, " diff"}, 32'(bus4.diff), 32'(ed));
      check({tag, " borrow_out"}, 32'(bus4.borrow_out), 32'(eb));
      @(negedge clk);
      check({tag, " done_single"}, 32'(bus4.done), 32'd0);
   endtask

   initial begin
      int cyc, d1, d2, dcount;

      rst = 1'b1;
      bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.borrow_in = 1'b0;
      bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(bus8.busy), 32'd0);
      check("reset done", 32'(bus8.done), 32'd0);
      check("reset diff", 32'(bus8.diff), 32'd0);
      check("reset borrow_out", 32'(bus8.borrow_out), 32'd0);
      check("reset w4 diff", 32'(bus4.diff), 32'd0);
      rst = 1'b0;

      // Basic results.
      op8("5A-23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
      op8("10-20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
      op8("FF-FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

      // Start during SHIFT is ignored; start held in DONE chains a new op.
      @(posedge clk); #1;
      bus8.start = 1'b1; bus8.a_in = 8'h5A; bus8.b_in = 8'h23; bus8.borrow_in = 1'b0;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      cyc = 0; d1 = -1; d2 = -1;
      while (d2 < 0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (bus8.done) begin
            if (d1 < 0) begin
               d1 = cyc;
               check("ignore diff", 32'(bus8.diff), 32'h37);
               check("ignore borrow_out", 32'(bus8.borrow_out), 32'd0);
               bus8.start = 1'b1; bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.borrow_in = 1'b0;
            end else begin
               d2 = cyc;
               check("b2b diff", 32'(bus8.diff), 32'hF0);
               check("b2b borrow_out", 32'(bus8.borrow_out), 32'd1);
            end
         end else if (cyc == 4) begin
            bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'h01; bus8.borrow_in = 1'b1;
         end else begin
            bus8.start = 1'b0;
         end
      end
      check("ignore done cycle", d1, 9);
      check("b2b done cycle", d2, 18);
      @(negedge clk);
      check("b2b done_single", 32'(bus8.done), 32'd0);

      // Reset in cycle 4 aborts: outputs cleared, no done pulse.
      @(posedge clk); #1;
      bus8.start = 1'b1; bus8.a_in = 8'h33; bus8.b_in = 8'h11; bus8.borrow_in = 1'b0;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort busy", 32'(bus8.busy), 32'd0);
      check("abort done", 32'(bus8.done), 32'd0);
      check("abort diff", 32'(bus8.diff), 32'd0);
      check("abort borrow_out", 32'(bus8.borrow_out), 32'd0);
      rst = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done) dcount++;
      end
      check("abort no done", dcount, 0);

      // Borrow-in cases, run after the abort.
      op8("00-00-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
      op8("80-7F-1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

      // Exhaustive 4-bit sweep.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               op4(4'(a), 4'(b), 1'(c));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
